// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF digit-stream blocks.
// Digit encoding and collector state encoding.
package msdf_pkg;

    localparam int DIGIT_WIDTH     = 3;
    localparam int DIGIT_PLUS_BIT  = 1;
    localparam int DIGIT_MINUS_BIT = 0;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/msdf_otf_conv.sv
// On-the-fly signed-digit to two's-complement converter.
// Keeps Q and QM = Q - 1 so every digit is a pure shift/select.
module msdf_otf_conv #(
    parameter int OUT_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 init,
    input  logic                 shift,
    input  logic                 plus,
    input  logic                 minus,
    output logic [OUT_WIDTH-1:0] q,
    output logic [OUT_WIDTH-1:0] qm,
    output logic [OUT_WIDTH-1:0] q_next
);

    logic                 pos;
    logic                 neg;
    logic [OUT_WIDTH-1:0] qm_next;

    assign pos = plus & ~minus;
    assign neg = minus & ~plus;

    always_comb begin
        q_next  = {q[OUT_WIDTH-2:0], 1'b0};
        qm_next = {qm[OUT_WIDTH-2:0], 1'b1};
        unique case (1'b1)
            pos: begin
                q_next  = {q[OUT_WIDTH-2:0], 1'b1};
                qm_next = {q[OUT_WIDTH-2:0], 1'b0};
            end
            neg: begin
                q_next  = {qm[OUT_WIDTH-2:0], 1'b1};
                qm_next = {qm[OUT_WIDTH-2:0], 1'b0};
            end
            default: ;
        endcase
    end

    // init wins: the word-closing digit is consumed via q_next only
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q  <= '0;
            qm <= '1;
        end else if (init) begin
            q  <= '0;
            qm <= '1;
        end else if (shift) begin
            q  <= q_next;
            qm <= qm_next;
        end
    end

endmodule

// File: rtl/msdf_digit_collector.sv
// Collects P MSDF digits and presents the converted
// two's-complement word on an elastic valid/ready output.
import msdf_pkg::*;

module msdf_digit_collector #(
    parameter  int TARGET_PRECISION = 16,
    localparam int OUT_WIDTH        = TARGET_PRECISION + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DIGIT_WIDTH-1:0] dataInArray_0,
    input  logic                   pValidArray_0,
    output logic                   readyArray_0,
    output logic [OUT_WIDTH-1:0]   dataOutArray_0,
    output logic                   validArray_0,
    input  logic                   nReadyArray_0
);

    localparam int CW = $clog2(TARGET_PRECISION);
    localparam logic [CW-1:0] LAST = CW'(TARGET_PRECISION - 1);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 valid_next;
    logic                 load;
    logic                 conv_init;
    logic                 dig_xfer;
    logic [OUT_WIDTH-1:0] conv_q;
    logic [OUT_WIDTH-1:0] conv_qm;
    logic [OUT_WIDTH-1:0] conv_q_next;
    logic                 unused_conv;

    assign dig_xfer    = pValidArray_0 & readyArray_0;
    assign unused_conv = ^{conv_q, conv_qm, dataInArray_0[2]};

    msdf_otf_conv #(
        .OUT_WIDTH(OUT_WIDTH)
    ) u_conv (
        .clk   (clk),
        .rstn  (rstn),
        .init  (conv_init),
        .shift (dig_xfer),
        .plus  (dataInArray_0[DIGIT_PLUS_BIT]),
        .minus (dataInArray_0[DIGIT_MINUS_BIT]),
        .q     (conv_q),
        .qm    (conv_qm),
        .q_next(conv_q_next)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        valid_next   = validArray_0;
        readyArray_0 = 1'b1;
        load         = 1'b0;
        conv_init    = 1'b0;
        unique case (state)
            COLLECT: begin
                if (pValidArray_0) begin
                    if (cnt == LAST) begin
                        load       = 1'b1;
                        conv_init  = 1'b1;
                        valid_next = 1'b1;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                readyArray_0 = nReadyArray_0;
                // a digit taken here is digit 1 of the next word
                if (nReadyArray_0) begin
                    valid_next = 1'b0;
                    state_next = COLLECT;
                    cnt_next   = pValidArray_0 ? CW'(1) : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= COLLECT;
            cnt            <= '0;
            validArray_0   <= 1'b0;
            dataOutArray_0 <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            validArray_0 <= valid_next;
            if (load) begin
                dataOutArray_0 <= conv_q_next;
            end
        end
    end

endmodule

// File: tb/tb_msdf_digit_collector.sv
// Directed and throttled-random checks for msdf_digit_collector.
// Expected words come from hand constants and a digit-sum model.
module tb_msdf_digit_collector;

    localparam int P = 16;

    localparam logic [2:0] DZ  = 3'b000;
    localparam logic [2:0] DP  = 3'b010;
    localparam logic [2:0] DM  = 3'b001;
    localparam logic [2:0] DZZ = 3'b011;
    localparam logic [2:0] DPR = 3'b110;

    typedef logic [2:0] word_t [P];

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  din = '0;
    logic        pvalid = 1'b0;
    logic        nready = 1'b0;
    logic        ready;
    logic        valid;
    logic [16:0] dout;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit rand_done = 1'b0;
    logic [16:0] res_q[$];
    int          cyc_q[$];
    logic [16:0] exp_q[$];

    msdf_digit_collector #(
        .TARGET_PRECISION(P)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .dataInArray_0 (din),
        .pValidArray_0 (pvalid),
        .readyArray_0  (ready),
        .dataOutArray_0(dout),
        .validArray_0  (valid),
        .nReadyArray_0 (nready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // nready and valid are stable mid-cycle, so this predicts the edge
    always @(negedge clk) begin
        if (mon_en && rstn && valid && nready) begin
            res_q.push_back(dout);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input word_t w);
        int s;
        s = 0;
        for (int i = 0; i < P; i++)
            s += (int'(w[i][1]) - int'(w[i][0])) * (1 << (P - 1 - i));
        return s[16:0];
    endfunction

    // called and returns at posedge+1
    task automatic send_digit(input logic [2:0] d);
        logic rdy;
        int   n;
        din    = d;
        pvalid = 1'b1;
        rdy    = 1'b0;
        n      = 0;
        while (!rdy && n < 200) begin
            #1;
            rdy = ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("digit_timeout", {31'b0, rdy}, 1);
    endtask

    task automatic send_word(input word_t w);
        for (int i = 0; i < P; i++) send_digit(w[i]);
        pvalid = 1'b0;
    endtask

    task automatic run_word(input string tag, input word_t w,
                            input logic [16:0] exp);
        send_word(w);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_data"}, dout, exp);
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, valid, 0);
    endtask

    initial begin
        word_t w7;
        word_t wneg;
        word_t wallp;
        word_t wallm;
        word_t wzz;
        word_t wr;
        int c0;
        int n;

        for (int i = 0; i < P; i++) begin
            w7[i]    = (i >= 1 && i <= 3) ? DP : DZ;
            wneg[i]  = (i == 4 || i == 6) ? DM : DZ;
            wallp[i] = (i % 2 == 1) ? DPR : DP;
            wallm[i] = DM;
            wzz[i]   = DZZ;
        end

        rstn   = 1'b0;
        nready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", dout, 0);
        chk("rst_ready", ready, 1);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        run_word("w7_16", w7, 17'h07000);
        run_word("wneg", wneg, 17'h1F600);
        run_word("allp", wallp, 17'h0FFFF);
        run_word("allm", wallm, 17'h10001);
        run_word("zz", wzz, 17'h00000);

        // back-to-back words, no bubbles
        res_q.delete();
        cyc_q.delete();
        mon_en = 1'b1;
        c0 = cyc;
        for (int i = 0; i < P; i++) send_digit(w7[i]);
        for (int i = 0; i < P; i++) send_digit(wneg[i]);
        chk("b2b_cycles", cyc - c0, 2 * P);
        pvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("b2b_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            chk("b2b_first", res_q[0], 17'h07000);
            chk("b2b_second", res_q[1], 17'h1F600);
            chk("b2b_gap", cyc_q[1] - cyc_q[0], P);
        end

        // backpressure with a pending digit
        nready = 1'b0;
        send_word(wallp);
        chk("bp_valid", valid, 1);
        pvalid = 1'b1;
        din    = wallm[0];
        repeat (5) begin
            #1;
            chk("bp_ready", ready, 0);
            chk("bp_hold", dout, 17'h0FFFF);
            chk("bp_hold_valid", valid, 1);
            @(posedge clk);
            #1;
        end
        nready = 1'b1;
        #1;
        chk("bp_ready_up", ready, 1);
        @(posedge clk);
        #1;
        chk("bp_released", valid, 0);
        for (int i = 1; i < P; i++) send_digit(wallm[i]);
        pvalid = 1'b0;
        chk("bp_next_valid", valid, 1);
        chk("bp_next_data", dout, 17'h10001);
        @(posedge clk);
        #1;

        // reset while holding a result
        nready = 1'b0;
        send_word(wallp);
        chk("rh_pre_valid", valid, 1);
        #3 rstn = 1'b0;
        #1;
        chk("rh_valid", valid, 0);
        chk("rh_data", dout, 0);
        chk("rh_ready", ready, 1);
        @(posedge clk);
        #1 rstn = 1'b1;
        nready = 1'b1;

        // reset mid-word after 7 digits
        for (int i = 0; i < 7; i++) send_digit(DP);
        #3 rstn = 1'b0;
        pvalid = 1'b0;
        #1;
        chk("rm_valid", valid, 0);
        chk("rm_data", dout, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        run_word("post_rst", w7, 17'h07000);

        // throttled random words
        res_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        fork
            begin
                while (!rand_done) begin
                    nready = ($urandom_range(3) != 0);
                    @(posedge clk);
                    #1;
                end
                nready = 1'b1;
            end
            begin
                for (int k = 0; k < 1000; k++) begin
                    for (int i = 0; i < P; i++)
                        wr[i] = 3'($urandom_range(7));
                    exp_q.push_back(model(wr));
                    for (int i = 0; i < P; i++) begin
                        if ($urandom_range(3) == 0) begin
                            pvalid = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send_digit(wr[i]);
                    end
                end
                pvalid = 1'b0;
                n = 0;
                while (res_q.size() < 1000 && n < 1000) begin
                    @(posedge clk);
                    n++;
                end
                rand_done = 1'b1;
            end
        join
        #1;
        mon_en = 1'b0;
        chk("rnd_count", res_q.size(), 1000);
        for (int k = 0; k < 1000 && k < res_q.size(); k++)
            chk("rnd_word", res_q[k], exp_q[k]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
